// File: rtl/alu_pipe_param_pkg.sv
`default_nettype none
// ALU_pkg: opcode encoding and the saturation helper shared by the pipelined ALU and its bench. Rev 1.0
package ALU_pkg;

  typedef enum logic [2:0] {
    Add           = 3'd0,
    Sub           = 3'd1,
    Not_A         = 3'd2,
    ReductionOR_B = 3'd3,
    And_AB        = 3'd4,
    Or_AB         = 3'd5,
    Xor_AB        = 3'd6,
    Acc           = 3'd7
  } opcode_e;

  localparam int CLAMP_W = 64;

  // Clamp a signed value into the (width+1)-bit signed range [-2^width, 2^width-1].
  function automatic logic signed [CLAMP_W-1:0] sat_clamp(input logic signed [CLAMP_W-1:0] value,
                                                         input int width);
    logic signed [CLAMP_W-1:0] hi;
    logic signed [CLAMP_W-1:0] lo;
    hi = (64'sd1 <<< width) - 64'sd1;
    lo = -(64'sd1 <<< width);
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_comb_core.sv
`default_nettype none
// alu_comb_core: stage-2 operation mux and accumulate overflow detect. Rev 1.0
module alu_comb_core
  import ALU_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter bit SAT_EN = 1'b0
) (
  input  opcode_e                 op,
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  input  logic signed [WIDTH:0]   acc,
  output logic signed [WIDTH:0]   result,
  output logic                    ovf
);

  localparam int W1 = WIDTH + 1;
  localparam int W2 = WIDTH + 2;

  logic signed [W1-1:0] a_ext;
  logic signed [W1-1:0] b_ext;
  logic signed [W2-1:0] acc_sum;

  assign a_ext   = W1'(a);
  assign b_ext   = W1'(b);
  // One guard bit above the result width exposes signed overflow of the accumulate.
  assign acc_sum = W2'(acc) + W2'(a);

  always_comb begin
    result = '0;
    ovf    = 1'b0;
    unique case (op)
      Add:           result = a_ext + b_ext;
      Sub:           result = a_ext - b_ext;
      Not_A:         result = W1'(~a);
      ReductionOR_B: result = {{WIDTH{1'b0}}, |b};
      And_AB:        result = W1'(a & b);
      Or_AB:         result = W1'(a | b);
      Xor_AB:        result = W1'(a ^ b);
      Acc: begin
        ovf    = acc_sum[W2-1] != acc_sum[W2-2];
        result = SAT_EN ? W1'(sat_clamp(CLAMP_W'(acc_sum), WIDTH)) : acc_sum[W1-1:0];
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_pipe_param.sv
`default_nettype none
// alu_pipe_param: 2-stage pipelined ALU with accumulator, optional saturation, sticky overflow. Rev 1.0
module alu_pipe_param
  import ALU_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter bit SAT_EN = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  opcode_e                 Opcode,
  input  logic signed [WIDTH-1:0] A,
  input  logic signed [WIDTH-1:0] B,
  input  logic                    acc_clr,
  output logic signed [WIDTH:0]   C,
  output logic                    out_valid,
  output logic                    ovf_sticky
);

  logic                    s1_valid;
  logic                    s1_clr;
  opcode_e                 s1_op;
  logic signed [WIDTH-1:0] s1_a;
  logic signed [WIDTH-1:0] s1_b;
  logic signed [WIDTH:0]   acc;
  logic signed [WIDTH:0]   acc_base;
  logic signed [WIDTH:0]   result;
  logic                    ovf;
  logic                    acc_fire;

  // A pending clear is applied before a same-stage accumulate adds to it.
  assign acc_base = s1_clr ? '0 : acc;
  assign acc_fire = s1_valid && (s1_op == Acc);

  alu_comb_core #(
    .WIDTH  (WIDTH),
    .SAT_EN (SAT_EN)
  ) u_core (
    .op     (s1_op),
    .a      (s1_a),
    .b      (s1_b),
    .acc    (acc_base),
    .result (result),
    .ovf    (ovf)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_clr   <= 1'b0;
      s1_op    <= Add;
      s1_a     <= '0;
      s1_b     <= '0;
    end else begin
      s1_valid <= in_valid;
      s1_clr   <= acc_clr;
      if (in_valid) begin
        s1_op <= Opcode;
        s1_a  <= A;
        s1_b  <= B;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      C          <= '0;
      out_valid  <= 1'b0;
      acc        <= '0;
      ovf_sticky <= 1'b0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) C <= result;
      if (acc_fire) begin
        acc        <= result;
        ovf_sticky <= (ovf_sticky && !s1_clr) || ovf;
      end else if (s1_clr) begin
        acc        <= '0;
        ovf_sticky <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_pipe_param.sv
`default_nettype none
// tb_alu_pipe_param: directed and random checks of both SAT_EN variants against an integer model. Rev 1.0
module tb_alu_pipe_param;
  import ALU_pkg::*;

  localparam int W  = 4;
  localparam int W1 = W + 1;
  localparam int HI = (1 << W) - 1;
  localparam int LO = -(1 << W);

  typedef struct {
    bit      v;
    opcode_e op;
    int      a;
    int      b;
    bit      clr;
  } op_t;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                in_valid = 1'b0;
  opcode_e             Opcode = Add;
  logic signed [W-1:0] A = '0;
  logic signed [W-1:0] B = '0;
  logic                acc_clr = 1'b0;
  logic signed [W:0]   c0, c1;
  logic                ov0, ov1, st0, st1;

  int total = 0;
  int bad   = 0;

  int m_acc[2];
  bit m_st[2];
  int m_c[2];
  bit m_v[2];
  op_t pend;

  always #5 clk = ~clk;

  alu_pipe_param #(.WIDTH(W), .SAT_EN(1'b0)) dut_wrap (
    .clk(clk), .reset(reset), .in_valid(in_valid), .Opcode(Opcode), .A(A), .B(B),
    .acc_clr(acc_clr), .C(c0), .out_valid(ov0), .ovf_sticky(st0)
  );

  alu_pipe_param #(.WIDTH(W), .SAT_EN(1'b1)) dut_sat (
    .clk(clk), .reset(reset), .in_valid(in_valid), .Opcode(Opcode), .A(A), .B(B),
    .acc_clr(acc_clr), .C(c1), .out_valid(ov1), .ovf_sticky(st1)
  );

  task automatic chk(input string tag, input logic [W:0] got, input logic [W:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, $signed(got), $signed(want));
    end
  endtask

  function automatic int wrap(input int v);
    int m;
    m = 1 << W1;
    return (((v + (1 << W)) % m) + m) % m - (1 << W);
  endfunction

  // Architectural effect of one operation reaching the result stage.
  task automatic model_apply(input op_t p, input int i);
    int sum;
    m_v[i] = p.v;
    if (p.clr) begin
      m_acc[i] = 0;
      m_st[i]  = 1'b0;
    end
    if (p.v) begin
      case (p.op)
        Add:           m_c[i] = p.a + p.b;
        Sub:           m_c[i] = p.a - p.b;
        Not_A:         m_c[i] = -p.a - 1;
        ReductionOR_B: m_c[i] = (p.b != 0) ? 1 : 0;
        And_AB:        m_c[i] = p.a & p.b;
        Or_AB:         m_c[i] = p.a | p.b;
        Xor_AB:        m_c[i] = p.a ^ p.b;
        default: begin
          sum = m_acc[i] + p.a;
          if (sum > HI || sum < LO) begin
            m_st[i] = 1'b1;
            m_c[i]  = (i == 1) ? int'(sat_clamp(64'(sum), W)) : wrap(sum);
          end else begin
            m_c[i] = sum;
          end
          m_acc[i] = m_c[i];
        end
      endcase
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_acc[i] = 0;
      m_st[i]  = 1'b0;
      m_c[i]   = 0;
      m_v[i]   = 1'b0;
    end
  endtask

  task automatic step(input string label, input bit v, input opcode_e op, input int a,
                      input int b, input bit clr, input bit rst);
    reset    = rst;
    in_valid = v;
    Opcode   = op;
    A        = a[W-1:0];
    B        = b[W-1:0];
    acc_clr  = clr;
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
      pend.v = 1'b0; pend.op = Add; pend.a = 0; pend.b = 0; pend.clr = 1'b0;
    end else begin
      model_apply(pend, 0);
      model_apply(pend, 1);
      pend.v = v; pend.op = op; pend.a = a; pend.b = b; pend.clr = clr;
    end
    chk({label, "/wrap/out_valid"}, {{W{1'b0}}, ov0}, {{W{1'b0}}, m_v[0]});
    chk({label, "/sat/out_valid"},  {{W{1'b0}}, ov1}, {{W{1'b0}}, m_v[1]});
    chk({label, "/wrap/C"}, c0, m_c[0][W:0]);
    chk({label, "/sat/C"},  c1, m_c[1][W:0]);
    chk({label, "/wrap/ovf_sticky"}, {{W{1'b0}}, st0}, {{W{1'b0}}, m_st[0]});
    chk({label, "/sat/ovf_sticky"},  {{W{1'b0}}, st1}, {{W{1'b0}}, m_st[1]});
  endtask

  initial begin
    pend.v = 1'b0; pend.op = Add; pend.a = 0; pend.b = 0; pend.clr = 1'b0;
    model_reset();

    step("reset", 1'b0, Add, 0, 0, 1'b0, 1'b1);
    chk("reset/C literal", c0, W1'(0));

    step("add", 1'b1, Add, 7, 7, 1'b0, 1'b0);
    step("sub", 1'b1, Sub, -8, 7, 1'b0, 1'b0);
    chk("add 7+7 literal", c0, W1'(14));
    step("not", 1'b1, Not_A, 5, 0, 1'b0, 1'b0);
    chk("sub -8-7 literal", c0, W1'(-15));
    step("ror0", 1'b1, ReductionOR_B, 0, 0, 1'b0, 1'b0);
    chk("not 5 literal", c0, W1'(-6));
    step("ror8", 1'b1, ReductionOR_B, 0, -8, 1'b0, 1'b0);
    chk("redor 0 literal", c0, W1'(0));
    step("xor", 1'b1, Xor_AB, 5, 3, 1'b0, 1'b0);
    chk("redor -8 literal", c1, W1'(1));
    step("and", 1'b1, And_AB, -1, -8, 1'b0, 1'b0);
    chk("xor 5^3 literal", c0, W1'(6));
    step("idle0", 1'b0, Add, 0, 0, 1'b0, 1'b0);
    chk("and -1&-8 literal", c1, W1'(-8));

    step("acc1", 1'b1, Acc, 7, 0, 1'b0, 1'b0);
    step("acc2", 1'b1, Acc, 7, 0, 1'b0, 1'b0);
    chk("acc first literal", c0, W1'(7));
    step("acc3", 1'b1, Acc, 7, 0, 1'b0, 1'b0);
    chk("acc second literal", c1, W1'(14));
    step("idle1", 1'b0, Add, 0, 0, 1'b0, 1'b0);
    chk("acc wrap literal", c0, W1'(-11));
    chk("acc sat literal", c1, W1'(15));
    chk("sticky sat literal", {{W{1'b0}}, st1}, W1'(1));
    step("accclr", 1'b1, Acc, 3, 0, 1'b1, 1'b0);
    step("idle2", 1'b0, Add, 0, 0, 1'b0, 1'b0);
    chk("acc after clear literal", c1, W1'(3));
    chk("sticky cleared literal", {{W{1'b0}}, st1}, W1'(0));

    step("inflight", 1'b1, Add, 1, 2, 1'b0, 1'b0);
    step("flush", 1'b1, Add, 3, 3, 1'b0, 1'b1);
    chk("flush out_valid literal", {{W{1'b0}}, ov0}, W1'(0));
    step("postflush", 1'b0, Add, 0, 0, 1'b0, 1'b0);
    chk("postflush C literal", c0, W1'(0));
    step("acc_after_rst", 1'b1, Acc, 2, 0, 1'b0, 1'b0);
    step("idle3", 1'b0, Add, 0, 0, 1'b0, 1'b0);
    chk("acc restarted literal", c0, W1'(2));

    for (int n = 0; n < 100; n++) begin
      step("rand", 1'($urandom_range(0, 1)), opcode_e'(3'($urandom_range(0, 7))),
           int'($urandom_range(0, 15)) - 8, int'($urandom_range(0, 15)) - 8,
           ($urandom_range(0, 9) == 0), 1'b0);
    end
    step("drain0", 1'b0, Add, 0, 0, 1'b0, 1'b0);
    step("drain1", 1'b0, Add, 0, 0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
